// File: rtl/mem_responder_pkg.sv
// Shared definitions for the deterministic-latency memory responder:
// FSM encoding, latency bounds and counter sizing.
package mem_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2,
        ST_DUMP = 2'd3
    } state_t;

    localparam int LAT_MIN = 2;
    localparam int LAT_MAX = 15;
    localparam int DATA_W  = 16;

    // One counter serves both the latency countdown (4 bits) and the dump sweep.
    function automatic int cnt_width(input int addr_bits);
        return (addr_bits > 4) ? addr_bits : 4;
    endfunction

endpackage

// File: rtl/mem_responder_mem_array.sv
// Single-port word storage: synchronous write, registered read. Request reads
// and dump reads land in separate registers so a dump never disturbs DataOut.
module mem_array
    import mem_responder_pkg::*;
#(
    parameter int ADDR_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_BITS-1:0] i_addr,
    input  logic                 i_we,
    input  logic [DATA_W-1:0]    i_wdata,
    input  logic                 i_re,
    input  logic                 i_dre,
    output logic [DATA_W-1:0]    o_rdata,
    output logic [DATA_W-1:0]    o_ddata
);

    logic [DATA_W-1:0] r_mem [2**ADDR_BITS];
    logic [DATA_W-1:0] r_rdata;
    logic [DATA_W-1:0] r_ddata;

    // Storage is deliberately not reset; contents survive rst.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (i_dre) begin
            r_ddata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;
    assign o_ddata = r_ddata;

endmodule

// File: rtl/mem_responder.sv
// Target side of the Rd/Wr/Done/Stall memory protocol: accepts one request,
// stalls for LATENCY-1 cycles, performs the access and pulses Done.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int ADDR_BITS = 8,
    parameter int LATENCY   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [15:0]          Addr,
    input  logic [15:0]          DataIn,
    input  logic                 Rd,
    input  logic                 Wr,
    input  logic                 createdump,
    output logic [15:0]          DataOut,
    output logic                 Done,
    output logic                 Stall,
    output logic                 err,
    output logic                 DumpValid,
    output logic [ADDR_BITS-1:0] DumpAddr,
    output logic [15:0]          DumpData
);

    localparam int                   CNT_W    = cnt_width(ADDR_BITS);
    localparam logic [ADDR_BITS-1:0] LAST_IDX = {ADDR_BITS{1'b1}};

    if (LATENCY < LAT_MIN || LATENCY > LAT_MAX) begin : g_bad_latency
        $error("mem_responder: LATENCY must be within 2..15");
    end

    state_t               r_state;
    state_t               w_next;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     w_cnt;
    logic                 r_op_wr;
    logic                 r_err;
    logic [ADDR_BITS-1:0] r_idx;
    logic [15:0]          r_wdata;

    logic                 w_req;
    logic                 w_bad;
    logic                 w_accept;
    logic [ADDR_BITS-1:0] w_dump_idx;
    logic [ADDR_BITS-1:0] w_maddr;
    logic                 w_we;
    logic                 w_re;
    logic                 w_dre;
    logic [15:0]          w_rdata;
    logic [15:0]          w_ddata;
    logic                 w_unused;

    // Byte address above the word index wraps; those bits are intentionally dropped.
    assign w_unused   = ^Addr[15:ADDR_BITS+1];

    assign w_req      = Rd | Wr;
    assign w_bad      = (Rd & Wr) | Addr[0];
    assign w_accept   = (r_state == ST_IDLE) && !createdump && w_req;
    assign w_dump_idx = r_cnt[ADDR_BITS-1:0];

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_op_wr <= 1'b0;
            r_err   <= 1'b0;
            r_idx   <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt;
            if (w_accept) begin
                r_op_wr <= Wr;
                r_err   <= w_bad;
                r_idx   <= Addr[ADDR_BITS:1];
                r_wdata <= DataIn;
            end
        end
    end

    always_comb begin
        w_next  = r_state;
        w_cnt   = r_cnt;
        w_maddr = r_idx;
        w_we    = 1'b0;
        w_re    = 1'b0;
        w_dre   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (createdump) begin
                    // Prefetch word 0 so DumpData is valid in the first DUMP cycle.
                    w_next  = ST_DUMP;
                    w_cnt   = '0;
                    w_maddr = '0;
                    w_dre   = 1'b1;
                end else if (w_req) begin
                    if (w_bad) begin
                        w_next = ST_RESP;
                    end else begin
                        w_next = ST_BUSY;
                        w_cnt  = CNT_W'(LATENCY - 1);
                    end
                end
            end
            ST_BUSY: begin
                w_cnt = r_cnt - 1'b1;
                if (r_cnt == CNT_W'(1)) begin
                    w_next = ST_RESP;
                    w_we   = r_op_wr;
                    w_re   = !r_op_wr;
                end
            end
            ST_RESP: begin
                w_next = ST_IDLE;
            end
            ST_DUMP: begin
                if (w_dump_idx == LAST_IDX) begin
                    w_next = ST_IDLE;
                    w_cnt  = '0;
                end else begin
                    w_cnt   = r_cnt + 1'b1;
                    w_maddr = w_dump_idx + 1'b1;
                    w_dre   = 1'b1;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
        // Reset must abort a write that happens to land on the reset edge.
        if (!rst) begin
            w_we = 1'b0;
        end
    end

    mem_array #(
        .ADDR_BITS (ADDR_BITS)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .i_addr  (w_maddr),
        .i_we    (w_we),
        .i_wdata (r_wdata),
        .i_re    (w_re),
        .i_dre   (w_dre),
        .o_rdata (w_rdata),
        .o_ddata (w_ddata)
    );

    assign Done      = (r_state == ST_RESP);
    assign err       = (r_state == ST_RESP) && r_err;
    assign Stall     = (r_state == ST_BUSY) || (r_state == ST_DUMP);
    assign DumpValid = (r_state == ST_DUMP);
    assign DumpAddr  = DumpValid ? w_dump_idx : '0;
    assign DumpData  = w_ddata;
    assign DataOut   = w_rdata;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: expectations queued at issue, compared
// when Done or DumpValid appears.
module tb_mem_responder;

    localparam int L = 4;

    typedef struct {
        logic        err;
        logic        rd;
        logic [15:0] data;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [15:0] Addr;
    logic [15:0] DataIn;
    logic        Rd;
    logic        Wr;
    logic        createdump;
    logic [15:0] DataOut;
    logic        Done;
    logic        Stall;
    logic        err;
    logic        DumpValid;
    logic [7:0]  DumpAddr;
    logic [15:0] DumpData;

    int          n_chk = 0;
    int          n_err = 0;
    exp_t        sb[$];
    logic [23:0] dq[$];
    logic [15:0] model [256];
    logic [15:0] last_dout;
    exp_t        me;
    logic [23:0] md;
    exp_t        he;

    mem_responder #(.ADDR_BITS(8), .LATENCY(L)) dut (
        .clk        (clk),
        .rst        (rst),
        .Addr       (Addr),
        .DataIn     (DataIn),
        .Rd         (Rd),
        .Wr         (Wr),
        .createdump (createdump),
        .DataOut    (DataOut),
        .Done       (Done),
        .Stall      (Stall),
        .err        (err),
        .DumpValid  (DumpValid),
        .DumpAddr   (DumpAddr),
        .DumpData   (DumpData)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic req(input logic rd, input logic wr, input logic [15:0] addr,
                       input logic [15:0] data);
        exp_t e;
        int   lat;
        logic bad;
        bad = (rd & wr) | addr[0];
        @(posedge clk); #1;
        Rd = rd; Wr = wr; Addr = addr; DataIn = data;
        e.err  = bad;
        e.rd   = rd & !bad;
        e.data = model[addr[8:1]];
        if (!bad && wr) model[addr[8:1]] = data;
        sb.push_back(e);
        lat = bad ? 1 : L;
        for (int c = 1; c <= lat; c++) begin
            @(posedge clk); #1;
            Rd = 1'b0; Wr = 1'b0;
            @(negedge clk);
            chk("stall", 32'(Stall), 32'(c < lat));
            chk("done", 32'(Done), 32'(c == lat));
        end
    endtask

    // Completion / dump monitor
    always @(negedge clk) begin
        if (!rst) begin
            last_dout = 16'h0;
        end else begin
            if (Done) begin
                if (sb.size() == 0) begin
                    chk("done_unexpected", 32'(Done), 32'd0);
                end else begin
                    me = sb.pop_front();
                    chk("err", 32'(err), 32'(me.err));
                    if (me.rd) begin
                        chk("rdata", 32'(DataOut), 32'(me.data));
                        last_dout = me.data;
                    end else begin
                        chk("dout_keep", 32'(DataOut), 32'(last_dout));
                    end
                end
            end else begin
                chk("err_no_done", 32'(err), 32'd0);
                chk("dout_keep", 32'(DataOut), 32'(last_dout));
            end
            if (DumpValid) begin
                if (dq.size() == 0) begin
                    chk("dump_unexpected", 32'(DumpValid), 32'd0);
                end else begin
                    md = dq.pop_front();
                    chk("dump_addr", 32'(DumpAddr), 32'(md[23:16]));
                    chk("dump_data", 32'(DumpData), 32'(md[15:0]));
                end
            end
        end
    end

    initial begin
        rst = 1'b0; Rd = 1'b0; Wr = 1'b0; Addr = '0; DataIn = '0; createdump = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_done", 32'(Done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_stall", 32'(Stall), 32'd0);
        chk("rst_dvalid", 32'(DumpValid), 32'd0);
        chk("rst_dout", 32'(DataOut), 32'd0);
        chk("rst_daddr", 32'(DumpAddr), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        // known background so every later read/dump has a defined expectation
        for (int i = 0; i < 256; i++) req(1'b0, 1'b1, 16'(i * 2), 16'hC000 | 16'(i));

        req(1'b0, 1'b1, 16'h0010, 16'hBEEF);
        req(1'b1, 1'b0, 16'h0010, 16'h0000);
        req(1'b1, 1'b0, 16'h0011, 16'h0000);
        req(1'b1, 1'b1, 16'h0020, 16'h5555);
        req(1'b1, 1'b0, 16'h0020, 16'h0000);
        req(1'b0, 1'b1, 16'h0202, 16'h1234);
        req(1'b1, 1'b0, 16'h0002, 16'h0000);
        req(1'b0, 1'b1, 16'h01FF, 16'h7777);
        req(1'b1, 1'b0, 16'h01FE, 16'h0000);

        // hold-through: Rd held into RESP, re-accepted only in cycle L+1
        @(posedge clk); #1;
        Rd = 1'b1; Wr = 1'b0; Addr = 16'h0010;
        he.err = 1'b0; he.rd = 1'b1; he.data = model[8];
        sb.push_back(he);
        for (int c = 1; c <= L; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("hold_stall", 32'(Stall), 32'(c < L));
            chk("hold_done", 32'(Done), 32'(c == L));
        end
        @(posedge clk); #1;
        @(negedge clk);
        chk("hold_idle_stall", 32'(Stall), 32'd0);
        chk("hold_idle_done", 32'(Done), 32'd0);
        sb.push_back(he);
        @(posedge clk); #1;
        Rd = 1'b0;
        @(negedge clk);
        chk("hold_reaccept", 32'(Stall), 32'd1);
        for (int c = 2; c <= L; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("hold2_stall", 32'(Stall), 32'(c < L));
            chk("hold2_done", 32'(Done), 32'(c == L));
        end

        // reset mid-write: pending write must be dropped
        @(posedge clk); #1;
        Wr = 1'b1; Addr = 16'h0004; DataIn = 16'hAAAA;
        @(posedge clk); #1;
        Wr = 1'b0;
        @(negedge clk);
        chk("rw_stall", 32'(Stall), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rw_done", 32'(Done), 32'd0);
        chk("rw_err", 32'(err), 32'd0);
        chk("rw_stall0", 32'(Stall), 32'd0);
        chk("rw_dvalid", 32'(DumpValid), 32'd0);
        chk("rw_dout", 32'(DataOut), 32'd0);
        chk("rw_daddr", 32'(DumpAddr), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        req(1'b1, 1'b0, 16'h0004, 16'h0000);

        // dump
        for (int i = 0; i < 4; i++) req(1'b0, 1'b1, 16'(i * 2), 16'(i + 1));
        @(posedge clk); #1;
        createdump = 1'b1;
        for (int i = 0; i < 256; i++) dq.push_back({8'(i), model[i]});
        for (int c = 1; c <= 256; c++) begin
            @(posedge clk); #1;
            createdump = 1'b0;
            @(negedge clk);
            chk("dump_valid", 32'(DumpValid), 32'd1);
            chk("dump_stall", 32'(Stall), 32'd1);
        end
        @(posedge clk); #1;
        @(negedge clk);
        chk("dump_end_valid", 32'(DumpValid), 32'd0);
        chk("dump_end_stall", 32'(Stall), 32'd0);

        req(1'b1, 1'b0, 16'h0006, 16'h0000);
        @(posedge clk); #1;
        chk("sb_left", 32'(sb.size()), 32'd0);
        chk("dq_left", 32'(dq.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
# mem_responder

Multi-cycle data-memory responder: the target end of the Rd/Wr/Done/Stall request protocol that the pipeline's memory stage drives. It latches one read or write request, holds Stall for a fixed latency, then performs the access and pulses Done with read data. It also performs a stalled full-array dump on createdump. The block is a drop-in, deterministic-latency memory used behind the MEM stage for stall and forwarding verification.

## Interface
- ADDR_BITS, 8, log2 of word depth (2^ADDR_BITS 16-bit words)
- LATENCY, 4, cycles from request acceptance to Done; legal range 2..15
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-low
- Addr  in  16  byte address; word index = Addr[ADDR_BITS:1], upper bits ignored (wrap)
- DataIn  in  16  write data, sampled with request
- Rd  in  1  read request
- Wr  in  1  write request
- createdump  in  1  start array dump
- DataOut  out  16  read data, registered
- Done  out  1  one-cycle completion pulse
- Stall  out  1  busy; requests ignored while high
- err  out  1  one-cycle error pulse, coincident with Done
- DumpValid  out  1  dump word valid
- DumpAddr  out  ADDR_BITS  dump word index
- DumpData  out  16  dump word contents

## Operation
- States: IDLE, BUSY, RESP, DUMP.
- IDLE, createdump=1: enter DUMP; has priority over Rd/Wr.
- IDLE, exactly one of Rd/Wr, Addr[0]=0: latch op, word index, DataIn; load counter with LATENCY-1; enter BUSY.
- IDLE, Rd&Wr both high, or Addr[0]=1: error request; no array access; enter RESP with err flag set.
- BUSY: decrement counter; on counter==1, perform the array write (Wr) or array read into DataOut (Rd) and enter RESP.
- RESP: Done=1, err=flag for exactly this cycle; return to IDLE. Rd/Wr ignored in RESP.
- DUMP: counter sweeps 0..2^ADDR_BITS-1; each cycle DumpValid=1, DumpAddr=index, DumpData=array[index]; after the last index, return to IDLE. No Done pulse.
- Stall=1 in BUSY and DUMP, 0 otherwise.
- DataOut holds last read value; it is unchanged by writes and errors.
- Array contents persist across reset (not cleared); DataOut is cleared.

## Timing
- Request sampled in cycle 0 (IDLE). Stall high cycles 1..LATENCY-1. Done high in cycle LATENCY. IDLE again in cycle LATENCY+1.
- Error request: Done=err=1 in cycle 1, Stall never asserted.
- Read data valid on DataOut in the Done cycle and held thereafter. A write is visible to a read accepted in any later cycle.
- Minimum request spacing is LATENCY+1 cycles. The initiator drops Rd/Wr on Done; a request held into RESP is not double-accepted.
- Dump: DumpValid is high for 2^ADDR_BITS consecutive cycles starting cycle 1. Stall covers exactly those cycles.
- Reset values (rst=0 at edge): state IDLE, Done=err=Stall=DumpValid=0, DataOut=0, DumpAddr=0, counter=0. Reset mid-BUSY aborts the access, and a pending write is not performed.
- All outputs are registered or decoded from state only; there is no combinational path from Rd/Wr to Done/Stall.

## Structure
- Shared package: state encoding (IDLE=2'd0, BUSY=2'd1, RESP=2'd2, DUMP=2'd3) and the LATENCY legality bounds.
- One sub-module: mem_array, a 2^ADDR_BITS x 16 synchronous-write, registered-read storage with a single port, muxed between request index and dump index.
- The FSM, counter and request latch live in mem_responder.

## Test plan
- Write then read: Wr Addr=0x0010 DataIn=0xBEEF, then Rd Addr=0x0010. Expect Done in cycle 4 of each, Stall in cycles 1-3, DataOut=0xBEEF on the read Done, err=0.
- Misaligned: Rd Addr=0x0011. Expect Done=err=1 in cycle 1, Stall=0, DataOut unchanged.
- Wrap: ADDR_BITS=8, Wr Addr=0x0202 DataIn=0x1234, then Rd Addr=0x0002. Expect DataOut=0x1234.
- Hold-through: the initiator keeps Rd high during Stall and into RESP. Expect exactly one Done, with the next acceptance only in cycle LATENCY+1.
- Reset mid-write: Wr Addr=0x0004 DataIn=0xAAAA, then rst=0 in cycle 2, then Rd Addr=0x0004. Expect the prior contents, all outputs zero during reset.
- Dump: preload words 0..3 = 0x0001..0x0004, pulse createdump. Expect 256 DumpValid cycles, DumpAddr 0..255 in order, DumpData matching the preload, then Stall=0.
